// File: rtl/gb_sysctl_pkg.sv
// gb_sysctl_pkg: shared types and default timing values for the
// Game Boy system controller (gb_sysctl and its clk_en divider).
//   state_e         - sequencer states INIT -> SETTLE -> RUN
//   *_DEF           - default parameter values for DIV_FAST, SLOW_MUL,
//                     INIT_TICKS and HOLD_TICKS
//   TICK_W          - width of the sequencer tick counter
//   tick_last()     - terminal count for an N-tick wait (N-1, counter is 0-based)
package gb_sysctl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int DIV_FAST_DEF   = 5;
  localparam int SLOW_MUL_DEF   = 4;
  localparam int INIT_TICKS_DEF = 15;
  localparam int HOLD_TICKS_DEF = 15;

  localparam int TICK_W = 16;

  function automatic logic [TICK_W-1:0] tick_last(input int ticks);
    return TICK_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/gb_sysctl_div.sv
// gb_sysctl_div: system tick divider.
// Produces a one-cycle clk_en every DIV_FAST clk cycles, or every
// DIV_FAST*SLOW_MUL cycles while slow mode is in force. The period choice
// is only re-evaluated at the wrap, so a running period is never cut short.
// Optional feature macro: GB_SYSCTL_SLOW_EN (without it, slow is ignored
// and only the fast period exists).
// Ports:
//   clk     - clock, rising edge
//   n_reset - synchronous active-low reset
//   slow    - requested slow mode, sampled at each wrap
//   clk_en  - registered one-cycle tick enable
module gb_sysctl_div
  import gb_sysctl_pkg::*;
#(
  parameter int DIV_FAST = DIV_FAST_DEF,
  parameter int SLOW_MUL = SLOW_MUL_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic slow,
  output logic clk_en
);

`ifdef GB_SYSCTL_SLOW_EN
  localparam int PERIOD_MAX = DIV_FAST * SLOW_MUL;
`else
  localparam int PERIOD_MAX = DIV_FAST;
`endif
  localparam int CW = $clog2(PERIOD_MAX);

  logic [CW-1:0] cnt_q, cnt_d, last_s;
  logic          clk_en_q, clk_en_d;
  logic          wrap_s;

`ifdef GB_SYSCTL_SLOW_EN
  logic per_slow_q, per_slow_d;

  // Terminal count of the period currently running
  always_comb begin
    if (per_slow_q) begin
      last_s = CW'(DIV_FAST * SLOW_MUL - 1);
    end else begin
      last_s = CW'(DIV_FAST - 1);
    end
  end

  // Slow request only takes hold when the current period wraps
  always_comb begin
    if (wrap_s) begin
      per_slow_d = slow;
    end else begin
      per_slow_d = per_slow_q;
    end
  end

  // Register the period selection
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      per_slow_q <= 1'b0;
    end else begin
      per_slow_q <= per_slow_d;
    end
  end
`else
  logic unused_slow_s;
  assign unused_slow_s = slow | (SLOW_MUL == 0);
  assign last_s        = CW'(DIV_FAST - 1);
`endif

  assign wrap_s = (cnt_q == last_s);

  // Period counter; clk_en is raised for the cycle following the last count
  always_comb begin
    if (wrap_s) begin
      cnt_d    = {CW{1'b0}};
      clk_en_d = 1'b1;
    end else begin
      cnt_d    = cnt_q + CW'(1);
      clk_en_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q    <= {CW{1'b0}};
      clk_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign clk_en = clk_en_q;

endmodule

// File: rtl/gb_sysctl.sv
// gb_sysctl: Game Boy system controller.
// Generates the system tick (via gb_sysctl_div), waits for a settled PLL
// lock, then releases exactly one of NUM_DOMAINS mutually exclusive reset
// domains, holding all of them in reset for HOLD_TICKS after every mode
// change. Optional feature macro: GB_SYSCTL_SLOW_EN enables the slow-tick
// mode; without it slow is tied low and slow_wr/slow_din are ignored.
// Ports:
//   clk, n_reset    - clock and synchronous active-low reset
//   pll_locked      - PLL lock, already synchronous to clk
//   mode_sel        - requested active domain
//   slow_wr/din     - one-cycle write strobe and value for slow mode
//   clk_en          - one-cycle tick enable
//   dom_reset       - per-domain active-high reset
//   reset_done      - initial lock sequence complete (sticky)
//   busy            - high whenever not in RUN
//   slow            - current slow-mode state
module gb_sysctl
  import gb_sysctl_pkg::*;
#(
  parameter int DIV_FAST    = DIV_FAST_DEF,
  parameter int SLOW_MUL    = SLOW_MUL_DEF,
  parameter int INIT_TICKS  = INIT_TICKS_DEF,
  parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
  parameter int NUM_DOMAINS = 2
) (
  input  logic                                                  clk,
  input  logic                                                  n_reset,
  input  logic                                                  pll_locked,
  input  logic [((NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1)-1:0] mode_sel,
  input  logic                                                  slow_wr,
  input  logic                                                  slow_din,
  output logic                                                  clk_en,
  output logic [NUM_DOMAINS-1:0]                                dom_reset,
  output logic                                                  reset_done,
  output logic                                                  busy,
  output logic                                                  slow
);

  localparam int MW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  state_e                  state_q, state_d;
  logic [TICK_W-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]           mode_q, mode_d;
  logic                    reset_done_q, reset_done_d;
  logic [NUM_DOMAINS-1:0]  dom_reset_q, dom_reset_d;
  logic                    busy_q, busy_d;
  logic                    tick_s;
  logic                    slow_s;

`ifdef GB_SYSCTL_SLOW_EN
  logic slow_q, slow_d;

  // Slow-mode register: written in any sequencer state
  always_comb begin
    if (slow_wr) begin
      slow_d = slow_din;
    end else begin
      slow_d = slow_q;
    end
  end

  // Register slow mode
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= slow_d;
    end
  end

  assign slow_s = slow_q;
`else
  logic unused_slow_in_s;
  assign unused_slow_in_s = slow_wr ^ slow_din;
  assign slow_s           = 1'b0;
`endif

  gb_sysctl_div #(
    .DIV_FAST (DIV_FAST),
    .SLOW_MUL (SLOW_MUL)
  ) u_div (
    .clk     (clk),
    .n_reset (n_reset),
    .slow    (slow_s),
    .clk_en  (tick_s)
  );

  // Sequencer next state; a mode change outranks a completing tick
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    reset_done_d = reset_done_q;
    case (state_q)
      ST_INIT: begin
        if (!pll_locked) begin
          cnt_d = {TICK_W{1'b0}};
        end else if (tick_s) begin
          if (cnt_q == tick_last(INIT_TICKS)) begin
            state_d      = ST_SETTLE;
            cnt_d        = {TICK_W{1'b0}};
            mode_d       = mode_sel;
            reset_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SETTLE, ST_RUN: begin
        if (mode_sel != mode_q) begin
          state_d = ST_SETTLE;
          cnt_d   = {TICK_W{1'b0}};
          mode_d  = mode_sel;
        end else if ((state_q == ST_SETTLE) && tick_s) begin
          if (cnt_q == tick_last(HOLD_TICKS)) begin
            state_d = ST_RUN;
            cnt_d   = {TICK_W{1'b0}};
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {TICK_W{1'b0}};
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge.
  // An out-of-range mode matches no bit, so every domain stays in reset.
  always_comb begin
    busy_d = (state_d != ST_RUN);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      dom_reset_d[i] = !((state_d == ST_RUN) && (mode_d == MW'(i)));
    end
  end

  // Sequencer and output registers
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= {TICK_W{1'b0}};
      mode_q       <= {MW{1'b0}};
      reset_done_q <= 1'b0;
      dom_reset_q  <= {NUM_DOMAINS{1'b1}};
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      reset_done_q <= reset_done_d;
      dom_reset_q  <= dom_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign clk_en     = tick_s;
  assign dom_reset  = dom_reset_q;
  assign reset_done = reset_done_q;
  assign busy       = busy_q;
  assign slow       = slow_s;

endmodule

// File: tb/tb_gb_sysctl.sv
// Self-checking bench for gb_sysctl: table of directed vectors, hand-written
// multi-cycle sequences and randomized stimulus, all cross-checked every
// cycle against an event-level reference model.
module tb_gb_sysctl;

  localparam int DIV  = 5;
  localparam int MUL  = 4;
  localparam int INIT = 15;
  localparam int HOLD = 15;
  localparam int N    = 2;
`ifdef GB_SYSCTL_SLOW_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       pll_locked = 1'b0;
  logic [0:0] mode_sel = 1'b0;
  logic       slow_wr = 1'b0;
  logic       slow_din = 1'b0;
  logic       clk_en;
  logic [1:0] dom_reset;
  logic       reset_done, busy, slow;

  int n_checks = 0;
  int n_fail   = 0;

  gb_sysctl #(
    .DIV_FAST(DIV), .SLOW_MUL(MUL), .INIT_TICKS(INIT), .HOLD_TICKS(HOLD), .NUM_DOMAINS(N)
  ) dut (
    .clk(clk), .n_reset(n_reset), .pll_locked(pll_locked), .mode_sel(mode_sel),
    .slow_wr(slow_wr), .slow_din(slow_din), .clk_en(clk_en), .dom_reset(dom_reset),
    .reset_done(reset_done), .busy(busy), .slow(slow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phases: 0 = waiting for lock, 1 = holding after a mode change, 2 = running
  int m_elapsed, m_period, m_phase, m_ticks, m_mode;
  bit m_en, m_done, m_slow;

  task automatic model_edge();
    bit tick;
    if (!n_reset) begin
      m_elapsed = 0; m_period = DIV; m_en = 0;
      m_phase = 0; m_ticks = 0; m_mode = 0; m_done = 0; m_slow = 0;
    end else begin
      tick = m_en;
      m_elapsed++;
      m_en = (m_elapsed == m_period);
      if (m_en) begin
        m_elapsed = 0;
        m_period  = m_slow ? DIV * MUL : DIV;
      end
      if (SB && slow_wr) m_slow = slow_din;
      if (m_phase == 0) begin
        if (!pll_locked) m_ticks = 0;
        else if (tick) begin
          m_ticks++;
          if (m_ticks == INIT) begin
            m_phase = 1; m_ticks = 0; m_mode = int'(mode_sel); m_done = 1;
          end
        end
      end else if (int'(mode_sel) != m_mode) begin
        m_phase = 1; m_ticks = 0; m_mode = int'(mode_sel);
      end else if (m_phase == 1 && tick) begin
        m_ticks++;
        if (m_ticks == HOLD) m_phase = 2;
      end
    end
  endtask

  function automatic logic [5:0] model_vec();
    int all_ones = (1 << N) - 1;
    int dom = (m_phase == 2 && m_mode < N) ? (all_ones & ~(1 << m_mode)) : all_ones;
    return {m_en, 2'(dom), m_done, (m_phase != 2), m_slow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model {en,dom,done,busy,slow}", 32'({clk_en, dom_reset, reset_done, busy, slow}),
          32'(model_vec()));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst_n_v;
    logic       pll;
    logic [0:0] mode;
    logic       wr;
    logic       din;
    int         cycles;
    logic       e_en;
    logic [1:0] e_dom;
    logic       e_done;
    logic       e_busy;
    logic       e_slow;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic p, input logic m, input logic w,
                              input logic d, input int c, input logic en, input logic [1:0] dom,
                              input logic dn, input logic bz, input logic sl);
    vec_t v;
    v.rst_n_v = r; v.pll = p; v.mode = m; v.wr = w; v.din = d; v.cycles = c;
    v.e_en = en; v.e_dom = dom; v.e_done = dn; v.e_busy = bz; v.e_slow = sl;
    return v;
  endfunction

  // Cycles until a pulse is seen, optionally writing slow mid-period
  task automatic gap(input bit do_wr, input bit din, output int g);
    g = 0;
    do begin
      slow_wr  = do_wr && (g == 1);
      slow_din = din;
      step();
      g++;
    end while (!clk_en && g < 200);
    slow_wr = 1'b0;
  endtask

  vec_t tbl [10];
  int   cyc, g;

  initial begin
    // Edge index after release: ticks seen at 5k+1, done at 76, RUN at 151
    tbl[0] = mk(0, 1, 0, 0, 0,  3, 0, 2'b11, 0, 1, 0);
    tbl[1] = mk(1, 1, 0, 0, 0, 75, 1, 2'b11, 0, 1, 0);
    tbl[2] = mk(1, 1, 0, 0, 0,  1, 0, 2'b11, 1, 1, 0);
    tbl[3] = mk(1, 1, 0, 0, 0, 74, 1, 2'b11, 1, 1, 0);
    tbl[4] = mk(1, 1, 0, 0, 0,  1, 0, 2'b10, 1, 0, 0);
    tbl[5] = mk(1, 1, 1, 0, 0,  1, 0, 2'b11, 1, 1, 0);
    tbl[6] = mk(1, 0, 1, 0, 0, 73, 1, 2'b11, 1, 1, 0);
    tbl[7] = mk(1, 0, 1, 0, 0,  1, 0, 2'b01, 1, 0, 0);
    tbl[8] = mk(1, 1, 1, 1, 1,  1, 0, 2'b01, 1, 0, SB);
    tbl[9] = mk(0, 1, 0, 0, 0,  1, 0, 2'b11, 0, 1, 0);

    for (int i = 0; i < 10; i++) begin
      n_reset = tbl[i].rst_n_v; pll_locked = tbl[i].pll; mode_sel = tbl[i].mode;
      slow_wr = tbl[i].wr; slow_din = tbl[i].din;
      for (int c = 0; c < tbl[i].cycles; c++) step();
      check($sformatf("tbl%0d clk_en", i),     32'(clk_en),     32'(tbl[i].e_en));
      check($sformatf("tbl%0d dom_reset", i),  32'(dom_reset),  32'(tbl[i].e_dom));
      check($sformatf("tbl%0d reset_done", i), 32'(reset_done), 32'(tbl[i].e_done));
      check($sformatf("tbl%0d busy", i),       32'(busy),       32'(tbl[i].e_busy));
      check($sformatf("tbl%0d slow", i),       32'(slow),       32'(tbl[i].e_slow));
    end
    slow_wr = 1'b0; mode_sel = 1'b0;

    // Lock glitch after ten counted ticks delays reset_done by ten ticks
    n_reset = 1'b1; pll_locked = 1'b1; cyc = 0;
    repeat (52) begin step(); cyc++; end
    pll_locked = 1'b0; step(); cyc++;
    pll_locked = 1'b1;
    while (!reset_done && cyc < 400) begin step(); cyc++; end
    check("glitch reset_done edge", 32'(cyc), 32'(INIT * DIV + 1 + 10 * DIV));

    // Reset pulse during SETTLE aborts and the whole sequence repeats
    n_reset = 1'b0; step(); n_reset = 1'b1; cyc = 0;
    while (!reset_done && cyc < 400) begin step(); cyc++; end
    check("reset_done edge", 32'(cyc), 32'(INIT * DIV + 1));
    repeat (20) step();
    n_reset = 1'b0; step();
    check("abort outputs", 32'({clk_en, dom_reset, reset_done, busy, slow}), 32'(6'b0_11_0_1_0));
    n_reset = 1'b1; cyc = 0;
    while (!(dom_reset == 2'b10 && !busy) && cyc < 1000) begin step(); cyc++; end
    check("abort run edge", 32'(cyc), 32'((INIT + HOLD) * DIV + 1));

    // Slow writes: running period is never shortened or stretched
    cyc = 0;
    while (!clk_en && cyc < 100) begin step(); cyc++; end
    check("slow sync", 32'(clk_en), 32'(1));
    gap(1'b1, 1'b1, g);
    check("gap write1", 32'(g), 32'(DIV));
    check("slow after write1", 32'(slow), 32'(SB));
    gap(1'b0, 1'b0, g);
    check("gap slow", 32'(g), 32'(SB ? DIV * MUL : DIV));
    gap(1'b1, 1'b0, g);
    check("gap write0", 32'(g), 32'(SB ? DIV * MUL : DIV));
    check("slow after write0", 32'(slow), 32'(0));
    gap(1'b0, 1'b0, g);
    check("gap fast", 32'(g), 32'(DIV));

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      n_reset    = ($urandom_range(0, 1499) != 0);
      pll_locked = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 249) == 0) mode_sel = ~mode_sel;
      slow_wr    = ($urandom_range(0, 79) == 0);
      slow_din   = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
